// File: rtl/divclk_serializer_pkg.sv
// Shared types and sizing helpers for the divided-clock serializer slice.
package divclk_serializer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_SHIFT = 2'd2
    } state_e;

    localparam int WIDTH_DEFAULT = 16;

    // Bit counter must hold WIDTH-1; never narrower than one bit.
    function automatic int bcnt_width(input int w);
        return ($clog2(w) < 1) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/divclk_edge.sv
// Turns the divided clock into one-clk rise/fall strobes in the clk domain.
module divclk_edge (
    input  logic clk,
    input  logic rst,
    input  logic div_clk,
    output logic rise,
    output logic fall
);

    logic div_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= 1'b0;
        end else begin
            div_q <= div_clk;
        end
    end

    assign rise = div_clk & ~div_q;
    assign fall = ~div_clk & div_q;

endmodule

// File: rtl/divclk_serializer.sv
// MSB-first 3-wire serializer paced by div_clk falls, with start/busy/done handshake.
module divclk_serializer
    import divclk_serializer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_clk,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic             busy,
    output logic             done,
    output logic             sclk,
    output logic             sdo,
    output logic             cs_n
);

    localparam int BW = bcnt_width(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [BW-1:0]    bcnt_q, bcnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             sclk_q, sclk_d;
    logic             sdo_q, sdo_d;
    logic             cs_n_q, cs_n_d;
    logic             rise, fall;

    divclk_edge u_edge (
        .clk     (clk),
        .rst     (rst),
        .div_clk (div_clk),
        .rise    (rise),
        .fall    (fall)
    );

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        bcnt_d  = bcnt_q;
        cs_n_d  = cs_n_q;
        sdo_d   = sdo_q;
        done_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    shreg_d = data_in;
                    bcnt_d  = BW'(WIDTH - 1);
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                if (fall) begin
                    cs_n_d  = 1'b0;
                    sdo_d   = shreg_q[WIDTH-1];
                    shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // Rise is the receiver's sampling point; only falls advance the frame.
                if (fall) begin
                    if (bcnt_q == '0) begin
                        cs_n_d  = 1'b1;
                        sdo_d   = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        sdo_d   = shreg_q[WIDTH-1];
                        shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                        bcnt_d  = bcnt_q - 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);

        // sclk tracks div_clk only inside the frame and changes on the same edge as sdo/cs_n.
        if (cs_n_d) begin
            sclk_d = 1'b0;
        end else if (rise) begin
            sclk_d = 1'b1;
        end else if (fall) begin
            sclk_d = 1'b0;
        end else begin
            sclk_d = sclk_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            bcnt_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sclk_q  <= 1'b0;
            sdo_q   <= 1'b0;
            cs_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            bcnt_q  <= bcnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sclk_q  <= sclk_d;
            sdo_q   <= sdo_d;
            cs_n_q  <= cs_n_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sclk = sclk_q;
    assign sdo  = sdo_q;
    assign cs_n = cs_n_q;

endmodule

// File: tb/tb_divclk_serializer.sv
// Self-checking bench: fall-counting frame model, per-cycle compare, directed scenarios.
module tb_divclk_serializer;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         div_clk;
    logic         start;
    logic [W-1:0] data_in;
    logic         busy, done, sclk, sdo, cs_n;

    int checks = 0;
    int errors = 0;

    divclk_serializer #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .div_clk (div_clk),
        .start   (start),
        .data_in (data_in),
        .busy    (busy),
        .done    (done),
        .sclk    (sclk),
        .sdo     (sdo),
        .cs_n    (cs_n)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- divided-clock source (bench-side divider) ----------------
    int   divide  = 4;
    int   div_cnt = 0;
    logic freeze  = 1'b0;
    logic gen_fell = 1'b0;

    always @(negedge clk) begin
        gen_fell = 1'b0;
        if (!freeze || div_clk) begin
            div_cnt++;
            if (div_cnt >= divide / 2) begin
                div_cnt = 0;
                div_clk = ~div_clk;
                gen_fell = ~div_clk;
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- frame model: counts div_clk falls after acceptance ----------------
    logic         m_prev = 1'b0;
    logic         m_busy = 1'b0, m_done = 1'b0, m_cs_n = 1'b1, m_sdo = 1'b0, m_sclk = 1'b0;
    logic [W-1:0] m_word = '0;
    int           m_nf = -1;

    always @(posedge clk) begin
        logic f;
        f = m_prev & ~div_clk;
        m_done = 1'b0;
        if (rst) begin
            m_busy = 1'b0;
            m_cs_n = 1'b1;
            m_sdo  = 1'b0;
            m_nf   = -1;
        end else if (!m_busy) begin
            if (start) begin
                m_word = data_in;
                m_busy = 1'b1;
                m_nf   = -1;
            end
        end else if (f) begin
            m_nf++;
            if (m_nf == W) begin
                m_busy = 1'b0;
                m_cs_n = 1'b1;
                m_sdo  = 1'b0;
                m_done = 1'b1;
                m_nf   = -1;
            end else begin
                m_cs_n = 1'b0;
                m_sdo  = m_word[W-1-m_nf];
            end
        end
        m_sclk = div_clk & ~m_cs_n;
        m_prev = rst ? 1'b0 : div_clk;
    end

    // ---------------- per-cycle compare and link monitor ----------------
    logic         p_sclk = 1'b0, p_cs_n = 1'b1;
    logic [W-1:0] cap = '0, last_frame = '0;
    int           ncap = 0, cs_cnt = 0, last_n = 0, last_cs = 0, done_cnt = 0;

    always @(posedge clk) begin
        #1;
        check("busy", busy, m_busy);
        check("done", done, m_done);
        check("cs_n", cs_n, m_cs_n);
        check("sdo",  sdo,  m_sdo);
        check("sclk", sclk, m_sclk);
        if (p_cs_n && !cs_n) begin
            cap = '0;
            ncap = 0;
            cs_cnt = 0;
        end
        if (!cs_n) cs_cnt++;
        if (!p_sclk && sclk) begin
            cap = {cap[W-2:0], sdo};
            ncap++;
        end
        if (done) begin
            done_cnt++;
            last_frame = cap;
            last_n = ncap;
            last_cs = cs_cnt;
        end
        p_sclk = sclk;
        p_cs_n = cs_n;
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [W-1:0] word);
        @(negedge clk);
        start = 1'b1;
        data_in = word;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done !== 1'b1 && n < budget);
        check(name, done, 1'b1);
    endtask

    initial begin
        int c0, d0, n;
        rst = 1'b1;
        start = 1'b0;
        data_in = '0;
        div_clk = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_sclk", sclk, 1'b0);
        check("rst_sdo",  sdo,  1'b0);
        check("rst_cs_n", cs_n, 1'b1);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // divide=4 frame with literal bit pattern and frame length
        d0 = done_cnt;
        send(16'hA5C3);
        check("a5_busy_after_accept", busy, 1'b1);
        wait_done("a5_done_timeout", 200);
        check("a5_bits", last_frame, 16'b1010010111000011);
        check("a5_nbits", last_n, 16);
        check("a5_cs_low", last_cs, 64);
        check("a5_busy_at_done", busy, 1'b0);
        check("a5_one_done", done_cnt - d0, 1);

        // divide=2 back-to-back frames, second start the cycle after done
        repeat (7) @(negedge clk);
        divide = 2;
        repeat (6) @(negedge clk);
        send(16'hFFFF);
        wait_done("ff_done_timeout", 200);
        check("ff_bits", last_frame, 16'hFFFF);
        check("ff_cs_low", last_cs, 32);
        start = 1'b1;
        data_in = 16'h0001;
        @(negedge clk);
        start = 1'b0;
        check("b2b_accept", busy, 1'b1);
        wait_done("01_done_timeout", 200);
        check("01_bits", last_frame, 16'h0001);
        check("01_cs_low", last_cs, 32);

        // start held mid-frame with other data must be ignored
        divide = 4;
        repeat (8) @(negedge clk);
        d0 = done_cnt;
        send(16'h1234);
        repeat (20) @(negedge clk);
        start = 1'b1;
        data_in = 16'hFFFF;
        repeat (30) @(negedge clk);
        start = 1'b0;
        wait_done("hold_done_timeout", 200);
        check("hold_bits", last_frame, 16'h1234);
        repeat (100) @(negedge clk);
        check("hold_one_done", done_cnt - d0, 1);
        check("hold_idle", busy, 1'b0);

        // start coincident with a div_clk fall: cs_n drops at the following fall
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!gen_fell && n < 20);
        check("fall_found", gen_fell, 1'b1);
        start = 1'b1;
        data_in = 16'h8001;
        c0 = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (cs_n !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("fall_cs_latency", cyc - c0, 4);
        wait_done("fall_done_timeout", 200);
        check("fall_bits", last_frame, 16'h8001);

        // reset during bit 7 aborts the frame without done
        repeat (5) @(negedge clk);
        d0 = done_cnt;
        send(16'hC3A5);
        n = 0;
        while (m_nf != 7 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("bit7_reached", m_nf, 7);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_cs_n", cs_n, 1'b1);
        check("abort_sclk", sclk, 1'b0);
        check("abort_sdo",  sdo,  1'b0);
        check("abort_busy", busy, 1'b0);
        repeat (10) @(negedge clk);
        check("abort_no_done", done_cnt - d0, 0);
        send(16'h3C5A);
        wait_done("fresh_done_timeout", 200);
        check("fresh_bits", last_frame, 16'h3C5A);
        check("fresh_nbits", last_n, 16);

        // stalled div_clk holds the block in ARM until it resumes
        repeat (5) @(negedge clk);
        freeze = 1'b1;
        repeat (4) @(negedge clk);
        check("frozen_low", div_clk, 1'b0);
        send(16'h5AA5);
        for (int i = 0; i < 4; i++) begin
            repeat (50) @(negedge clk);
            check("stall_busy", busy, 1'b1);
            check("stall_cs_n", cs_n, 1'b1);
        end
        freeze = 1'b0;
        wait_done("stall_done_timeout", 200);
        check("stall_bits", last_frame, 16'h5AA5);
        check("stall_cs_low", last_cs, 64);

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
